// File: rtl/div_pkg.sv
// Shared definitions for the sequential unsigned restoring divider.
// Provides the FSM state encoding and counter-width helpers.
// No ports; imported by unsigned_divider.
package div_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam int DEF_WIDTH = 4;

   // Step counter width for the default operand width; holds 0..WIDTH-1.
   localparam int CNT_W = $clog2(DEF_WIDTH);

   // Same rule for any operand width; never narrower than one bit.
   function automatic int cnt_width(input int w);
      return (w < 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/div_step.sv
// Purpose: one combinational restoring-division step (shift in a dividend bit, trial subtract).
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
// Ports: pr_in - partial remainder (WIDTH+1), divisor (WIDTH), dividend_bit - next dividend MSB,
//        pr_out - updated partial remainder, qbit - resulting quotient bit.
module div_step #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH:0]   pr_in,
   input  logic [WIDTH-1:0] divisor,
   input  logic             dividend_bit,
   output logic [WIDTH:0]   pr_out,
   output logic             qbit
);

   logic [WIDTH:0] shifted;

   always_comb begin
      // pr_in is always below the divisor, so the shift never loses its top bit.
      shifted = (pr_in << 1) | {{WIDTH{1'b0}}, dividend_bit};
      qbit    = 1'b0;
      pr_out  = shifted;
      if (shifted >= {1'b0, divisor}) begin
         qbit   = 1'b1;
         pr_out = shifted - {1'b0, divisor};
      end
   end

endmodule

// File: rtl/unsigned_divider.sv
// Purpose: sequential unsigned restoring divider, q = x / y and r = x % y, one quotient bit per clock.
// Latency: done is high in the cycle after edge E+WIDTH (E = accepting edge); back-to-back every WIDTH+2 cycles.
// Backpressure: en is sampled only in IDLE; en and operand changes while busy are ignored.
// Ports: clk, rst (async active-high), en (start), x (dividend), y (divisor),
//        q/r (registered quotient/remainder), busy, done (one-cycle pulse),
//        div_by_zero (present only when DIV_BY_ZERO_EN is defined; early exit on y==0).
module unsigned_divider
   import div_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] r,
   output logic             busy,
   output logic             done
`ifdef DIV_BY_ZERO_EN
   ,
   output logic             div_by_zero
`endif
);

   localparam int CW = cnt_width(WIDTH);

   state_t          state;
   logic [CW-1:0]   count;
   // Holds the dividend; each step shifts its MSB out and the new quotient bit in,
   // so after WIDTH steps it contains the quotient.
   logic [WIDTH-1:0] dq;
   logic [WIDTH-1:0] ysh;
   logic [WIDTH:0]   pr;
   logic [WIDTH:0]   pr_nxt;
   logic             qbit;

   div_step #(.WIDTH(WIDTH)) u_step (
      .pr_in        (pr),
      .divisor      (ysh),
      .dividend_bit (dq[WIDTH-1]),
      .pr_out       (pr_nxt),
      .qbit         (qbit)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         count <= '0;
         dq    <= '0;
         ysh   <= '0;
         pr    <= '0;
         q     <= '0;
         r     <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
`ifdef DIV_BY_ZERO_EN
         div_by_zero <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
`ifdef DIV_BY_ZERO_EN
         div_by_zero <= 1'b0;
`endif
         case (state)
            S_IDLE: begin
               if (en) begin
                  dq    <= x;
                  ysh   <= y;
                  pr    <= '0;
                  count <= '0;
                  busy  <= 1'b1;
                  state <= S_CALC;
               end
            end
            S_CALC: begin
`ifdef DIV_BY_ZERO_EN
               // Zero divisor: dq still holds the untouched dividend, report immediately.
               if (ysh == '0) begin
                  q           <= '1;
                  r           <= dq;
                  done        <= 1'b1;
                  div_by_zero <= 1'b1;
                  state       <= S_DONE;
               end else
`endif
               begin
                  dq    <= {dq[WIDTH-2:0], qbit};
                  pr    <= pr_nxt;
                  count <= count + 1'b1;
                  if (count == CW'(WIDTH - 1)) begin
                     q     <= {dq[WIDTH-2:0], qbit};
                     r     <= pr_nxt[WIDTH-1:0];
                     done  <= 1'b1;
                     state <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_unsigned_divider.sv
// Purpose: directed self-checking bench for unsigned_divider at WIDTH=4.
// Latency: expectations are hand-computed; zero-divisor latency depends on DIV_BY_ZERO_EN.
// Backpressure: covers operand changes while busy, mid-calculation reset and en held high.
module tb_unsigned_divider;

   logic       clk = 1'b1;
   logic       rst;
   logic       en;
   logic [3:0] x;
   logic [3:0] y;
   logic [3:0] q;
   logic [3:0] r;
   logic       busy;
   logic       done;
`ifdef DIV_BY_ZERO_EN
   logic       div_by_zero;
   localparam int DBZ_LAT = 1;
`else
   localparam int DBZ_LAT = 4;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   unsigned_divider #(.WIDTH(4)) dut (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .x    (x),
      .y    (y),
      .q    (q),
      .r    (r),
      .busy (busy),
      .done (done)
`ifdef DIV_BY_ZERO_EN
      ,
      .div_by_zero (div_by_zero)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Called at a falling edge with the divider idle; returns at a falling edge with it idle again.
   task automatic run_div(input string tag, input logic [3:0] xa, input logic [3:0] ya,
                          input logic [3:0] eq, input logic [3:0] er, input int lat);
      int k;
      logic busy_ok;
      x  = xa;
      y  = ya;
      en = 1'b1;
      @(negedge clk);
      // Accepting edge has passed: scramble the operands, they must not matter now.
      en = 1'b0;
      x  = 4'($urandom);
      y  = 4'($urandom);
      busy_ok = busy;
      k = 0;
      while (!done && k < 20) begin
         @(negedge clk);
         k++;
         if (!busy) busy_ok = 1'b0;
      end
      chk({tag, " latency"}, k, lat);
      chk({tag, " busy during op"}, busy_ok, 1);
      chk({tag, " q"}, q, eq);
      chk({tag, " r"}, r, er);
`ifdef DIV_BY_ZERO_EN
      chk({tag, " div_by_zero"}, div_by_zero, (ya == 4'd0) ? 1 : 0);
`endif
      @(negedge clk);
      chk({tag, " done pulse width"}, done, 0);
      chk({tag, " busy after"}, busy, 0);
      chk({tag, " q held"}, q, eq);
      chk({tag, " r held"}, r, er);
   endtask

   initial begin
      int k;
      rst = 1'b1;
      en  = 1'b0;
      x   = 4'd0;
      y   = 4'd0;
      #12;
      chk("reset q", q, 0);
      chk("reset r", r, 0);
      chk("reset busy", busy, 0);
      chk("reset done", done, 0);
`ifdef DIV_BY_ZERO_EN
      chk("reset div_by_zero", div_by_zero, 0);
`endif
      #3;
      rst = 1'b0;

      run_div("13/11", 4'd13, 4'd11, 4'd1,  4'd2, 4);
      run_div("3/5",   4'd3,  4'd5,  4'd0,  4'd3, 4);
      run_div("15/15", 4'd15, 4'd15, 4'd1,  4'd0, 4);
      run_div("15/1",  4'd15, 4'd1,  4'd15, 4'd0, 4);
      run_div("9/0",   4'd9,  4'd0,  4'd15, 4'd9, DBZ_LAT);
      run_div("14/4",  4'd14, 4'd4,  4'd3,  4'd2, 4);

      // Reset in the middle of a calculation: outputs clear at once, not at the next edge.
      x  = 4'd13;
      y  = 4'd3;
      en = 1'b1;
      @(negedge clk);
      en = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst q", q, 0);
      chk("midrst r", r, 0);
      chk("midrst busy", busy, 0);
      chk("midrst done", done, 0);
      @(negedge clk);
      rst = 1'b0;
      run_div("7/2 after rst", 4'd7, 4'd2, 4'd3, 4'd1, 4);

      // en held high: results repeat every WIDTH+2 cycles.
      x  = 4'd6;
      y  = 4'd4;
      en = 1'b1;
      k = 0;
      while (!done && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("held first done", done, 1);
      chk("held q", q, 1);
      chk("held r", r, 2);
      for (int n = 0; n < 2; n++) begin
         @(negedge clk);
         k = 1;
         while (!done && k < 20) begin
            @(negedge clk);
            k++;
         end
         chk("held done period", k, 6);
      end
      en = 1'b0;
      k = 0;
      while (busy && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("held drains to idle", busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
